// File: rtl/clocken_pkg.sv
// Shared types and helpers for the programmable clock-enable generator.
package clocken_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Divisors below MIN_DIV would make clken and clken2 collide; clamp them up.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/clocken_period.sv
// Period engine: cycle counter, active/pending divisor registers,
// half-period and end-of-period compares, and the slowclk/pulse outputs.
module clocken_period
  import clocken_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 div_load,
  input  logic                 active,       // RUN or STEP: counter advances
  input  logic                 start_run,    // leaving IDLE for RUN: preload count to P-1
  input  logic                 start_pulse,  // new period with a clken (RUN wrap or STEP entry)
  input  logic                 stop,         // period ends without a clken
  output logic                 at_end,
  output logic                 clken,
  output logic                 clken2,
  output logic                 slowclk
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] p;
  logic [DIV_WIDTH-1:0] pending;
  logic [DIV_WIDTH-1:0] pend_nxt;
  logic [DIV_WIDTH-1:0] p_nxt;
  logic                 at_half;
  logic                 boundary;

  // A load coinciding with a boundary is forwarded so that boundary uses it.
  always_comb begin
    pend_nxt = div_load ? DIV_WIDTH'(clamp_div(32'(div))) : pending;
    at_end   = (count == p - DIV_WIDTH'(1));
    at_half  = (count == (p >> 1) - DIV_WIDTH'(1));
    boundary = !active || at_end;
    p_nxt    = boundary ? pend_nxt : p;
  end

  // Counter, divisor registers and registered clock outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      p       <= DIV_WIDTH'(DEFAULT_DIV);
      pending <= DIV_WIDTH'(DEFAULT_DIV);
      clken   <= 1'b0;
      clken2  <= 1'b0;
      slowclk <= 1'b0;
    end else begin
      pending <= pend_nxt;
      p       <= p_nxt;
      clken   <= start_pulse;
      clken2  <= active && at_half;
      if (start_run)
        count <= p_nxt - DIV_WIDTH'(1);
      else if (start_pulse || stop || !active)
        count <= '0;
      else
        count <= count + DIV_WIDTH'(1);
      if (start_pulse)
        slowclk <= 1'b1;
      else if (!active || at_half)
        slowclk <= 1'b0;
    end
  end

endmodule

// File: rtl/clocken_prog.sv
// Programmable clock-enable generator: run/step/halt FSM and clken counter
// around the period engine.
module clocken_prog
  import clocken_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 50000,
  parameter int CYC_WIDTH   = 32
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 div_load,
  input  logic                 mode,
  input  logic                 step,
  input  logic                 halt,
  output logic                 clken,
  output logic                 clken2,
  output logic                 slowclk,
  output logic                 running,
  output logic [CYC_WIDTH-1:0] cycles
);

  state_t state;
  state_t state_nxt;
  logic   active;
  logic   start_run;
  logic   start_pulse;
  logic   stop;
  logic   at_end;

  clocken_period #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_period (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .div        (div),
    .div_load   (div_load),
    .active     (active),
    .start_run  (start_run),
    .start_pulse(start_pulse),
    .stop       (stop),
    .at_end     (at_end),
    .clken      (clken),
    .clken2     (clken2),
    .slowclk    (slowclk)
  );

  // Next-state and period commands; halt/mode are only honoured at period ends.
  always_comb begin
    state_nxt   = state;
    start_run   = 1'b0;
    start_pulse = 1'b0;
    stop        = 1'b0;
    active      = (state == RUN) || (state == STEP);
    case (state)
      IDLE: begin
        if (halt) begin
          state_nxt = HALTED;
        end else if (!mode) begin
          state_nxt = RUN;
          start_run = 1'b1;
        end else if (step) begin
          state_nxt   = STEP;
          start_pulse = 1'b1;
        end
      end
      RUN: begin
        if (at_end) begin
          if (halt) begin
            state_nxt = HALTED;
            stop      = 1'b1;
          end else if (mode) begin
            state_nxt = IDLE;
            stop      = 1'b1;
          end else begin
            start_pulse = 1'b1;
          end
        end
      end
      STEP: begin
        if (at_end) begin
          state_nxt = halt ? HALTED : IDLE;
          stop      = 1'b1;
        end
      end
      HALTED: begin
        if (!halt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, running flag and clken counter.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
      cycles  <= '0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN) || (state_nxt == STEP);
      if (start_pulse) cycles <= cycles + CYC_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_clocken_prog.sv
// Bench for clocken_prog with DEFAULT_DIV=4: per-cycle vector table checked
// through a scoreboard, plus an asynchronous reset sequence.
module tb_clocken_prog;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic [15:0] div;
  logic        div_load, mode, step, halt;
  logic        clken, clken2, slowclk, running;
  logic [31:0] cycles;

  int n_cmp = 0;
  int n_bad = 0;

  clocken_prog #(
    .DIV_WIDTH  (16),
    .DEFAULT_DIV(4),
    .CYC_WIDTH  (32)
  ) dut (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .div     (div),
    .div_load(div_load),
    .mode    (mode),
    .step    (step),
    .halt    (halt),
    .clken   (clken),
    .clken2  (clken2),
    .slowclk (slowclk),
    .running (running),
    .cycles  (cycles)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic        md, st, hl, ld;
    logic [15:0] dv;
    logic [35:0] exp;
  } vec_t;

  typedef struct {
    string       tag;
    logic [35:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  function automatic vec_t mk(input logic md, st, hl, ld, input int dv,
                              input logic ck, ck2, sc, rn, input int cy);
    vec_t v;
    v.md  = md; v.st = st; v.hl = hl; v.ld = ld;
    v.dv  = 16'(dv);
    v.exp = {ck, ck2, sc, rn, 32'(cy)};
    return v;
  endfunction

  task automatic compare(input string tag, input logic [35:0] e);
    logic [35:0] g;
    g = {clken, clken2, slowclk, running, cycles};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got clken=%b clken2=%b slowclk=%b running=%b cycles=%0d, want clken=%b clken2=%b slowclk=%b running=%b cycles=%0d",
               tag, g[35], g[34], g[33], g[32], g[31:0], e[35], e[34], e[33], e[32], e[31:0]);
    end
  endtask

  // Called at a negedge: drive, queue expectation, check after the next posedge.
  task automatic apply(input vec_t v, input string tag);
    sb_t s;
    mode = v.md; step = v.st; halt = v.hl; div_load = v.ld; div = v.dv;
    sb.push_back('{tag, v.exp});
    @(posedge sysclk);
    #1;
    s = sb.pop_front();
    compare(s.tag, s.exp);
    @(negedge sysclk);
  endtask

  initial begin
    // md st hl ld div | clken clken2 slowclk running cycles
    // free run, P=4
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,1,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,2));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,2));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,1,2));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,2));
    // load 5 on the boundary itself: next period is already 5
    tbl.push_back(mk(0,0,0,1,5, 1,0,1,1,3));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,3));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,1,3));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,3));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,3));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,4));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,4));
    // load 3 at count 1: this period stays 5
    tbl.push_back(mk(0,0,0,1,3, 0,1,0,1,4));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,4));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,4));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,5));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,1,5));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,5));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,6));
    // load 0 clamps to 2
    tbl.push_back(mk(0,0,0,1,0, 0,1,0,1,6));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,6));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,7));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,1,7));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,8));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,1,8));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,9));
    // switch to step mode with P=6
    tbl.push_back(mk(1,0,0,1,6, 0,1,0,1,9));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,9));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,9));
    tbl.push_back(mk(1,1,0,0,0, 1,0,1,1,10));
    tbl.push_back(mk(1,0,0,0,0, 0,0,1,1,10));
    tbl.push_back(mk(1,0,0,0,0, 0,0,1,1,10));
    tbl.push_back(mk(1,1,0,0,0, 0,1,0,1,10));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,1,10));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,1,10));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,10));
    // P=8 run, halt raised at count 2
    tbl.push_back(mk(1,0,0,1,8, 0,0,0,0,10));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,10));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,11));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,11));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,11));
    tbl.push_back(mk(0,0,1,0,0, 0,0,1,1,11));
    tbl.push_back(mk(0,0,1,0,0, 0,1,0,1,11));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,1,11));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,1,11));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,1,11));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,0,11));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,0,11));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,11));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,11));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,12));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,12));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,12));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,12));

    rst_n = 1'b0; div = '0; div_load = 1'b0; mode = 1'b0; step = 1'b0; halt = 1'b0;
    repeat (2) @(negedge sysclk);
    #1;
    compare("reset_state", 36'd0);
    @(negedge sysclk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("row%0d", i + 1));

    // Count 3 of a P=8 period: reset must clear outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1 compare("async_reset", 36'd0);
    @(negedge sysclk);
    rst_n = 1'b1;
    // Divisor back to DEFAULT_DIV=4 and cycles restarted from 0.
    for (int i = 0; i < 9; i++)
      apply(tbl[i], $sformatf("post_reset_row%0d", i + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
